// File: rtl/mem_tester.sv
// Built-in RAM tester: writes P everywhere, then read-compare/write ~P, then read-compare ~P.
// Records first-mismatch address/data and a saturating mismatch count.
module mem_tester #(
    parameter int ADDR_W = 3,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              clear,
    input  logic              start,
    input  logic [DATA_W-1:0] pattern,
    output logic              busy,
    output logic              done,
    output logic              fail,
    output logic [ADDR_W-1:0] err_addr,
    output logic [DATA_W-1:0] err_data,
    output logic [ADDR_W+1:0] err_count,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_din,
    input  logic [DATA_W-1:0] mem_dout
);

    localparam logic [2:0] IDLE = 3'd0;
    localparam logic [2:0] WR   = 3'd1;
    localparam logic [2:0] RMW  = 3'd2;
    localparam logic [2:0] RD   = 3'd3;
    localparam logic [2:0] DONE = 3'd4;

    logic [2:0]        state;
    logic [DATA_W-1:0] pat;
    logic              last;
    logic              mismatch;
    logic [DATA_W-1:0] expected;

    always_comb begin
        last     = (mem_addr == '1);
        expected = (state == RMW) ? pat : ~pat;
        mismatch = ((state == RMW) || (state == RD)) && (mem_dout != expected);
        busy     = (state == WR) || (state == RMW) || (state == RD);
        done     = (state == DONE);
        mem_we   = (state == WR) || (state == RMW);
        mem_din  = '0;
        if (state == WR)
            mem_din = pat;
        else if (state == RMW)
            mem_din = ~pat;
    end

    always_ff @(posedge clk) begin
        if (clear) begin
            state     <= IDLE;
            pat       <= '0;
            mem_addr  <= '0;
            fail      <= 1'b0;
            err_addr  <= '0;
            err_data  <= '0;
            err_count <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        pat       <= pattern;
                        mem_addr  <= '0;
                        fail      <= 1'b0;
                        err_addr  <= '0;
                        err_data  <= '0;
                        err_count <= '0;
                        state     <= WR;
                    end
                end
                // Address wraps to 0 naturally on the last increment of each phase.
                WR: begin
                    mem_addr <= mem_addr + 1'b1;
                    if (last) state <= RMW;
                end
                RMW: begin
                    mem_addr <= mem_addr + 1'b1;
                    if (last) state <= RD;
                end
                RD: begin
                    mem_addr <= mem_addr + 1'b1;
                    if (last) state <= DONE;
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase

            if (mismatch) begin
                fail <= 1'b1;
                if (err_count != '1)
                    err_count <= err_count + 1'b1;
                if (!fail) begin
                    err_addr <= mem_addr;
                    err_data <= mem_dout;
                end
            end
        end
    end

endmodule

// File: doc/mem_tester.md
MEM_TESTER -- requirements
Module: mem_tester

Interface
REQ-001 The module SHALL have parameter ADDR_W, default 3, meaning the RAM address width, so depth = 2^ADDR_W words.
REQ-002 The module SHALL have parameter DATA_W, default 8, meaning the RAM word width.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 clear  input  1  reset; synchronous, active-high.
REQ-005 start  input  1  request a test run; sampled only in IDLE.
REQ-006 pattern  input  DATA_W  test word P; latched when start is accepted.
REQ-007 busy  output  1  high while a run is in progress.
REQ-008 done  output  1  one-cycle pulse at end of a run.
REQ-009 fail  output  1  sticky flag; at least one mismatch in the current or last run.
REQ-010 err_addr  output  ADDR_W  address of first mismatch.
REQ-011 err_data  output  DATA_W  data read at first mismatch.
REQ-012 err_count  output  ADDR_W+2  mismatch count, saturating at all-ones.
REQ-013 mem_we  output  1  RAM write enable; the RAM writes on the rising edge.
REQ-014 mem_addr  output  ADDR_W  RAM address.
REQ-015 mem_din  output  DATA_W  RAM write data.
REQ-016 mem_dout  input  DATA_W  RAM read data; combinational from mem_addr, old contents before a write edge.

Function
REQ-017 The FSM SHALL have states IDLE, WR, RMW, RD, DONE.
REQ-018 IDLE: busy=0, mem_we=0. If start=1 at edge N, latch P, set mem_addr=0, and enter WR.
REQ-019 WR: mem_we=1, mem_din=P. mem_addr SHALL increment each cycle. At the last address, go to RMW with mem_addr=0.
REQ-020 RMW: compare mem_dout with P, and in the same cycle drive mem_we=1, mem_din=~P. Increment the address each cycle. At the last address, go to RD with mem_addr=0.
REQ-021 RD: mem_we=0, compare mem_dout with ~P. Increment the address each cycle. At the last address, go to DONE.
REQ-022 DONE: done=1 and busy=0 for exactly one cycle, then go to IDLE unconditionally.
REQ-023 Timing SHALL be: busy high on cycles N+1 through N+3*2^ADDR_W; done on the next cycle (N+25 at default).
REQ-024 On a mismatch: fail is set, err_count increments, and err_addr/err_data capture only if it is the first mismatch of the run.
REQ-025 The run SHALL continue after a mismatch; there is no early abort.
REQ-026 Accepting start SHALL clear fail, err_addr, err_data and err_count.
REQ-027 The error outputs SHALL hold their values after DONE until the next start or clear.
REQ-028 start while busy or in DONE SHALL be ignored; pattern changes during a run SHALL have no effect.
REQ-029 mem_addr SHALL wrap from the last address to 0 at each phase transition; no out-of-range address is ever driven.
REQ-030 mem_we SHALL be 0 in IDLE, RD and DONE.

Reset
REQ-031 With clear=1 at an edge, the next cycle SHALL be IDLE with busy=0, done=0, fail=0, err_addr=0, err_data=0, err_count=0, mem_we=0, mem_addr=0, mem_din=0.
REQ-032 clear SHALL take priority over start and over any state, including mid-run; no RAM write occurs in the cycle after clear is sampled.

Verification
REQ-033 Reset: hold clear=1 for 2 cycles from power-up -> all outputs 0, FSM in IDLE.
REQ-034 Good 8x8 RAM model, pattern=8'hA5, start pulse at edge N -> busy on N+1..N+24, done at N+25, fail=0, err_count=0; RAM contains 8'h5A at all 8 addresses.
REQ-035 RAM model with address 5 bit0 stuck at 0, pattern=8'h01 -> fail=1, err_addr=5, err_data=8'h00, err_count=1; the RD phase reads 8'hFE and matches.
REQ-036 RAM model with address 1 aliased onto address 0 (writes to 1 land in 0), pattern=8'h0F -> first mismatch at RMW addr 1 (old 8'h0F was not stored at 1): err_addr=1, err_count>=1, fail=1.
REQ-037 start held high during the whole run and again 3 cycles after done -> exactly one run per IDLE acceptance; a second run clears error flags.
REQ-038 clear=1 during RMW at mem_addr=3 -> next cycle IDLE, mem_we=0, busy=0, fail=0, no done pulse.
